// File: rtl/i281_pkg.sv
// Shared i281 definitions: decoded instruction classes and the multicycle sequencer states.
package i281_pkg;

  localparam int unsigned OpClassW = 3;

  typedef enum logic [OpClassW-1:0] {
    OpAlu    = 3'd0,
    OpLoad   = 3'd1,
    OpStore  = 3'd2,
    OpBranch = 3'd3,
    OpNop    = 3'd4,
    OpHalt   = 3'd5,
    OpIll6   = 3'd6,
    OpIll7   = 3'd7
  } op_class_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt,
    StFault
  } state_e;

  function automatic logic writes_reg(op_class_e cls);
    return (cls == OpAlu) || (cls == OpLoad);
  endfunction

  function automatic logic uses_mem(op_class_e cls);
    return (cls == OpLoad) || (cls == OpStore);
  endfunction

endpackage

// File: rtl/i281_mc_sequencer_if.sv
// Run control, memory handshake and datapath enable bundle between the sequencer and the core.
interface i281_mc_sequencer_if #(
  parameter int unsigned PC_W  = 6,
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic             step;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic [2:0]       op_class;
  logic             mem_ready;

  logic             mem_req;
  logic             ir_load;
  logic             flag_write;
  logic             reg_write;
  logic             dmem_write;
  logic             pc_write;
  logic             busy;
  logic             bp_hit;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] instr_count;

  // Sequencer side
  modport master (
    input  run, step, bp_en, bp_addr, pc, op_class, mem_ready,
    output mem_req, ir_load, flag_write, reg_write, dmem_write, pc_write,
           busy, bp_hit, halted, fault, instr_count
  );

  // Core / environment side
  modport slave (
    output run, step, bp_en, bp_addr, pc, op_class, mem_ready,
    input  mem_req, ir_load, flag_write, reg_write, dmem_write, pc_write,
           busy, bp_hit, halted, fault, instr_count
  );
endinterface

// File: rtl/i281_wait_timer.sv
// Consecutive memory-wait counter; expired flags the wait cycle that exhausts the budget.
module i281_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);
  localparam int unsigned W = 8;

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      cnt_q <= '0;
    end else if (count) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Current cycle is the TIMEOUT-th consecutive wait.
  assign expired = count && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/i281_mc_sequencer.sv
// Per-instruction multicycle FSM driving i281 datapath enables, with memory handshake,
// wait timeout, single-step / breakpoint run control and a retired-instruction counter.
module i281_mc_sequencer
  import i281_pkg::*;
#(
  parameter int unsigned PC_W    = 6,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input logic                 clock,
  input logic                 reset,
  i281_mc_sequencer_if.master bus
);

  state_e           state_q;
  op_class_e        cls_q;
  logic             step_pend_q;
  logic             bp_hit_q;
  logic [CNT_W-1:0] cnt_q;

  logic in_mem;
  logic expired;
  logic pc_match;
  logic bp_trip;
  logic go;
  logic absorbing;

  assign in_mem    = (state_q == StFetch) || (state_q == StMem);
  assign absorbing = (state_q == StHalt) || (state_q == StFault);
  assign pc_match  = (PC_W'(bus.pc) == PC_W'(bus.bp_addr));
  assign bp_trip   = bus.bp_en && pc_match && bus.run && !bp_hit_q;
  assign go        = (bus.run && !bp_hit_q) || step_pend_q || bus.step;

  i281_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_mem || bus.mem_ready),
    .count  (in_mem && !bus.mem_ready),
    .expired(expired)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      cls_q       <= OpNop;
      step_pend_q <= 1'b0;
      bp_hit_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (bus.step && !absorbing) begin
        step_pend_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (bp_trip) begin
            bp_hit_q <= 1'b1;
          end else if (go) begin
            // A step coinciding with FETCH entry is consumed by this instruction.
            state_q     <= StFetch;
            step_pend_q <= 1'b0;
            bp_hit_q    <= 1'b0;
          end
        end
        StFetch: begin
          if (bus.mem_ready) begin
            state_q <= StDecode;
          end else if (expired) begin
            state_q <= StFault;
          end
        end
        StDecode: begin
          cls_q <= op_class_e'(bus.op_class);
          case (op_class_e'(bus.op_class))
            OpAlu, OpLoad, OpStore, OpBranch: state_q <= StExec;
            OpNop:                            state_q <= StWb;
            OpHalt:                           state_q <= StHalt;
            default:                          state_q <= StFault;
          endcase
        end
        StExec: begin
          state_q <= uses_mem(cls_q) ? StMem : StWb;
        end
        StMem: begin
          if (bus.mem_ready) begin
            state_q <= StWb;
          end else if (expired) begin
            state_q <= StFault;
          end
        end
        StWb: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= StIdle;
        end
        StHalt, StFault: begin
          step_pend_q <= 1'b0;
        end
        default: state_q <= StFault;
      endcase
    end
  end

  assign bus.mem_req     = in_mem;
  assign bus.ir_load     = (state_q == StFetch) && bus.mem_ready;
  assign bus.flag_write  = (state_q == StExec) && (cls_q == OpAlu);
  assign bus.dmem_write  = (state_q == StMem) && bus.mem_ready && (cls_q == OpStore);
  assign bus.pc_write    = (state_q == StWb);
  assign bus.reg_write   = (state_q == StWb) && writes_reg(cls_q);
  assign bus.busy        = !(state_q == StIdle || absorbing);
  assign bus.bp_hit      = bp_hit_q;
  assign bus.halted      = (state_q == StHalt);
  assign bus.fault       = (state_q == StFault);
  assign bus.instr_count = cnt_q;

endmodule

// File: doc/i281_mc_sequencer.md
# i281_mc_sequencer

Parametrised multicycle instruction sequencer for the next-generation i281 core. It replaces the fixed multicycle decoder / opcode-multicycle pair with one explicit per-instruction FSM (IDLE, FETCH, DECODE, EXEC, MEM, WB). It adds a valid/ready handshake to code and data memory with a timeout fault, single-step and PC breakpoint run control, and a retired-instruction counter. It sits between the opcode decoder and the datapath enables: register file, flags, PC, and data memory.

## Interface
- `PC_W`, default 6: PC / breakpoint address width.
- `TIMEOUT`, default 15: maximum consecutive memory wait cycles before a fault. Range 1..255.
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the rising edge of `clock`.
- `run` input 1: level enable; while high, instructions are started back-to-back.
- `step` input 1: one-cycle pulse; executes exactly one instruction.
- `bp_en` input 1: breakpoint enable.
- `bp_addr` input `PC_W`: breakpoint PC.
- `pc` input `PC_W`: current PC from the PC register.
- `op_class` input 3: decoded class of the instruction register contents. Encodings: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 NOP, 5 HALT, 6/7 illegal.
- `mem_ready` input 1: memory accepts/completes the current request.
- `mem_req` output 1: memory request valid.
- `ir_load` output 1: capture instruction word.
- `flag_write` output 1: flags register enable.
- `reg_write` output 1: register file write enable.
- `dmem_write` output 1: data memory write enable.
- `pc_write` output 1: PC register enable.
- `busy` output 1: FSM not in IDLE, HALT or FAULT.
- `bp_hit` output 1: sticky, stopped at breakpoint.
- `halted` output 1: HALT state.
- `fault` output 1: FAULT state.
- `instr_count` output `CNT_W`: retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT. The class is latched in DECODE; later states use the latched class, not the live `op_class`.
- IDLE:
  - If `bp_en && pc==bp_addr && run && !bp_hit`: set `bp_hit`, stay in IDLE.
  - Else if `(run && !bp_hit) || step_pending`: go to FETCH and clear `step_pending` and `bp_hit`.
  - `step_pending` is set by a `step` pulse in any state other than HALT/FAULT. A second pulse while pending is absorbed.
  - When `run` and `step` are seen together with no `bp_hit`, `run` dominates and `step_pending` is cleared at the FETCH entry.
- FETCH:
  - `mem_req=1`.
  - On `mem_ready`: `ir_load=1` for that cycle, go to DECODE.
- DECODE, one cycle:
  - ALU, LOAD, STORE, BRANCH go to EXEC.
  - NOP goes to WB.
  - HALT goes to HALT.
  - 6/7 go to FAULT.
- EXEC, one cycle:
  - `flag_write=1` for ALU.
  - LOAD/STORE go to MEM; all others go to WB.
- MEM:
  - `mem_req=1`.
  - On `mem_ready`: `dmem_write=1` that cycle if STORE, go to WB.
- WB, one cycle:
  - `pc_write=1`.
  - `reg_write=1` for ALU/LOAD.
  - `instr_count` increments and wraps modulo 2^`CNT_W`.
  - Go to IDLE.
- Wait timer: counts consecutive cycles in FETCH/MEM with `mem_ready=0`. It clears on state entry and on ready. When the count reaches `TIMEOUT` with ready still low, the next state is FAULT and no enable is asserted.
- HALT and FAULT are absorbing; only reset leaves them. `run`/`step` are ignored there.
- Dropping `run` mid-instruction: the instruction completes through WB, then the FSM stays in IDLE.
- Reset at any point, including mid-MEM:
  - State returns to IDLE.
  - `step_pending`, `bp_hit`, the timer and `instr_count` are cleared.
  - All outputs are 0 in the cycle after reset is sampled. No partial write enable is issued.

## Timing
- Outputs are Moore from state, except these, which are combinational on `mem_ready` within FETCH/MEM: `ir_load`, `dmem_write`, and the exit condition.
- With `mem_ready` tied high, cycles per instruction counting the IDLE cycle: ALU/BRANCH 5, LOAD/STORE 6, NOP 4.
- Each memory wait cycle adds 1.
- `step` pulse in IDLE: FETCH is entered on the next edge.
- Breakpoint: `bp_hit` rises 1 cycle after IDLE with matching PC. A `step` while `bp_hit` is set executes the breakpointed instruction.

## Structure
- `i281_pkg` holds the `op_class` encoding constants and the state enum, shared with the opcode decoder.
- Sub-module `i281_wait_timer` implements the timeout counter: clear, count, and expired output.

## Test plan
- Run with `mem_ready=1` over the sequence ALU, LOAD, STORE, NOP:
  - `pc_write` pulses at cycles 5, 11, 17, 21.
  - `instr_count=4`.
  - `dmem_write` is a single pulse during the STORE's MEM state.
- Fetch with `mem_ready` low for 3 cycles, `TIMEOUT=15`:
  - FETCH lasts 4 cycles.
  - `ir_load` is high only on the ready cycle.
- `mem_ready` stuck low in MEM, `TIMEOUT=15`:
  - `fault=1` after 15 wait cycles.
  - No `dmem_write`/`reg_write`.
  - `run`/`step` are ignored until reset.
- `bp_en=1`, `bp_addr=3`, `run=1`, PC reaches 3:
  - `bp_hit` goes to 1 and the FSM stays in IDLE.
  - One `step` retires the instruction at PC 3.
  - With `run` still high, execution continues from PC 4.
- `op_class=5` (HALT): `halted=1` and `instr_count` unchanged. `op_class=7`: `fault=1`.
- Reset held low for one edge during MEM of a STORE:
  - Next cycle: IDLE, all outputs 0, `instr_count=0`, no `dmem_write` ever asserted for that STORE.
